native_port_bist: RTL and testbench
===================================

Name: native_port_bist

Overview:
- Write/read-back traffic generator and checker for the LiteDRAM native user port 0 (cmd/wdata/rdata).
- Sits between the board-level test controller (buttons/LEDs) and litedram_core, driving the user_port0_* signals in place of hand-sequenced single accesses.
- On a start pulse it writes LENGTH beats of a deterministic pattern from BASE, reads them back with pipelined reads, and reports pass/fail, an error count and (optionally) the first failing beat.

Parameters:
- ADDR_W, 25, native port beat address width.
- DATA_W, 256, native port data width; must be a multiple of 32.
- MAX_OUT, 8, maximum read commands outstanding (accepted but data not yet returned); power of two, 2..16.
- ERR_W, 16, error counter width.

Ports:
- user_clk  in  1  clock, rising edge; the litedram_core user_clk.
- user_rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- base_addr  in  ADDR_W  first beat address; sampled at start.
- length  in  ADDR_W  number of beats; sampled at start.
- seed  in  32  pattern seed; sampled at start.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- pass  out  1  valid while done; 1 means err_count==0.
- err_count  out  ERR_W  miscompared beats; saturates at all-ones.
- cmd_valid  out  1  to user_port0_cmd_valid.
- cmd_ready  in  1  from user_port0_cmd_ready.
- cmd_we  out  1  to user_port0_cmd_we.
- cmd_addr  out  ADDR_W  to user_port0_cmd_addr.
- wdata_valid  out  1  to user_port0_wdata_valid.
- wdata_ready  in  1  from user_port0_wdata_ready.
- wdata_we  out  DATA_W/8  to user_port0_wdata_we.
- wdata_data  out  DATA_W  to user_port0_wdata_data.
- rdata_valid  in  1  from user_port0_rdata_valid.
- rdata_ready  out  1  to user_port0_rdata_ready.
- rdata_data  in  DATA_W  from user_port0_rdata_data.

Behaviour:
- Clocking and reset:
  - Single clock domain, user_clk.
  - Reset is synchronous and active-low (user_rst_n). All outputs reset to 0 and the FSM resets to IDLE.
  - Reset mid-run abandons the run with no drain of outstanding reads. litedram_core is reset together with this block.
- Pattern: 32-bit lane i (0..DATA_W/32-1) of beat address a = seed ^ {i[2:0], 4'h0, a[24:0]}. Lane index bits above [2:0] are ignored.
- Addressing: beat k uses address (base_addr + k) mod 2^ADDR_W, so the address wraps silently.
- wdata_we is all-ones whenever wdata_valid is asserted, otherwise 0.
- FSM states:
  - IDLE: start is accepted. If length==0, go to DONE next cycle with pass=1 and err_count=0. Otherwise clear counters, deassert done, assert busy, go to WR_CMD.
  - WR_CMD: cmd_valid=1, cmd_we=1, cmd_addr=current address. On cmd_valid&&cmd_ready go to WR_DATA.
  - WR_DATA: wdata_valid=1 with the pattern for that address. On wdata_ready, advance the address. If the last beat was written go to RD, else go to WR_CMD.
  - RD: issue and check reads, described below. Leave when checked==length; go to DONE.
  - DONE: busy=0, done=1. A start here begins a new run exactly as from IDLE.
- Read issue: in RD, cmd_valid=1 and cmd_we=0 while issued<length and outstanding<MAX_OUT.
- Read check:
  - rdata_ready=1 throughout RD.
  - Each rdata_valid beat is compared against the pattern for the next expected address; returns are in order.
  - A mismatch increments err_count, saturating.
  - Outstanding count: +1 on an accepted read cmd, -1 on an rdata beat. Simultaneous events leave it unchanged.
- Back-to-back reads: one read cmd per cycle when cmd_ready is held high.
- Latency: start to first cmd_valid is 1 cycle. Last rdata beat to done is 1 cycle.
- start while busy is ignored. rdata_valid outside RD is ignored.

Optional Feature:
- Macro: NATIVE_PORT_BIST_ERRCAP_EN.
- When defined, add these outputs:
  - err_addr (ADDR_W): address of the first mismatched beat of the run.
  - err_data (DATA_W): read data of that beat.
  - err_valid (1): set on the first mismatch; cleared on start and on reset.
- When undefined, these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared package native_bist_pkg holds:
  - FSM state enum: IDLE, WR_CMD, WR_DATA, RD, DONE.
  - Lane pattern function: seed, lane, address -> 32-bit word.
  - Defaults for ADDR_W and DATA_W.
- One sub-module, bist_pattern_gen: combinational address+seed -> DATA_W pattern. It is instantiated twice, once for write data and once for the expected read data.

Test Plan:
- base=0, length=4, seed=0, ideal port (readies=1, read return latency 3) -> 4 writes to addresses 0..3; lane0 of beat 2 = 0x00000002, lane7 = 0xE0000002; done with pass=1 and err_count=0.
- Same run with the model corrupting bit 0 of beat 1 -> err_count=1, pass=0; with ERRCAP_EN, err_addr=1.
- base=0x1FFFFFE, length=4 -> cmd_addr sequence 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1 for both writes and reads; pass=1.
- Read latency 40 cycles, MAX_OUT=8, length=32 -> outstanding never exceeds 8; cmd_valid stalls at 8 outstanding; all 32 beats checked; pass=1.
- length=0 -> done one cycle after start, no cmd_valid ever asserted.
- user_rst_n low for one cycle during RD with 5 reads outstanding -> next cycle busy=0, done=0, all valids 0; a following start runs cleanly.

Source files
------------

// File: rtl/native_bist_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// native_bist_pkg : state encoding and per-lane data pattern for native_port_bist
// rev 1.0
// ----------------------------------------------------------------------------
package native_bist_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_DATA = 3'd2,
    RD      = 3'd3,
    DONE    = 3'd4
  } bist_state_e;

  // Lane index tags the top bits so lanes of one beat are never identical.
  function automatic logic [31:0] lane_pattern(
    input logic [31:0] seed,
    input logic [2:0]  lane,
    input logic [24:0] addr
  );
    return seed ^ {lane, 4'h0, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bist_pattern_gen : combinational beat address + seed -> full-width data pattern
// rev 1.0
// ----------------------------------------------------------------------------
module bist_pattern_gen
  import native_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  localparam int LANES = DATA_W / 32;

  logic [24:0] addr25;

  assign addr25 = 25'(addr);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pattern[32*i +: 32] = lane_pattern(seed, 3'(i), addr25);
  end

endmodule
`default_nettype wire

// File: rtl/native_port_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// native_port_bist : LiteDRAM native-port write/read-back BIST; optional
// first-error capture with NATIVE_PORT_BIST_ERRCAP_EN.   rev 1.0
// ----------------------------------------------------------------------------
module native_port_bist
  import native_bist_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = 8,
  parameter int ERR_W   = 16
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_we,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic                wdata_valid,
  input  logic                wdata_ready,
  output logic [DATA_W/8-1:0] wdata_we,
  output logic [DATA_W-1:0]   wdata_data,
  input  logic                rdata_valid,
  output logic                rdata_ready,
  input  logic [DATA_W-1:0]   rdata_data
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
  ,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_data,
  output logic                err_valid
`endif
);

  localparam int               OUT_W   = $clog2(MAX_OUT) + 1;
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0]  OUT_ONE = OUT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  E_ONE   = ERR_W'(1);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] chk_q, chk_d;
  logic [31:0]       seed_q, seed_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] wr_pat, exp_pat;
  logic              rd_issue, rd_acc, mismatch;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
  logic              errv_q, errv_d;
  logic [ADDR_W-1:0] erra_q, erra_d;
  logic [DATA_W-1:0] errd_q, errd_d;
`endif

  bist_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .seed    (seed_q),
    .addr    (addr_q),
    .pattern (wr_pat)
  );

  bist_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_exp_pat (
    .seed    (seed_q),
    .addr    (exp_q),
    .pattern (exp_pat)
  );

  assign rd_issue = (state_q == RD) && (cnt_q < len_q) && (out_q < OUT_MAX);
  assign rd_acc   = rd_issue && cmd_ready;
  assign mismatch = (rdata_data != exp_pat);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    chk_d       = chk_q;
    seed_d      = seed_q;
    out_d       = out_q;
    err_d       = err_q;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
    errv_d      = errv_q;
    erra_d      = erra_q;
    errd_d      = errd_q;
`endif
    busy        = 1'b0;
    done        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          len_d   = length;
          seed_d  = seed;
          addr_d  = base_addr;
          exp_d   = base_addr;
          cnt_d   = '0;
          chk_d   = '0;
          out_d   = '0;
          err_d   = '0;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
          errv_d  = 1'b0;
          erra_d  = '0;
          errd_d  = '0;
`endif
          state_d = (length == '0) ? DONE : WR_CMD;
        end
      end

      WR_CMD: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        if (cmd_ready) state_d = WR_DATA;
      end

      WR_DATA: begin
        busy        = 1'b1;
        wdata_valid = 1'b1;
        if (wdata_ready) begin
          addr_d = addr_q + A_ONE;
          cnt_d  = cnt_q + A_ONE;
          state_d = WR_CMD;
          // Read phase restarts from the base, which exp_q still holds.
          if (cnt_q + A_ONE == len_q) begin
            addr_d  = exp_q;
            cnt_d   = '0;
            state_d = RD;
          end
        end
      end

      RD: begin
        busy        = 1'b1;
        rdata_ready = 1'b1;
        cmd_valid   = rd_issue;
        if (rd_acc) begin
          addr_d = addr_q + A_ONE;
          cnt_d  = cnt_q + A_ONE;
        end
        if (rdata_valid) begin
          exp_d = exp_q + A_ONE;
          chk_d = chk_q + A_ONE;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + E_ONE;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
            if (!errv_q) begin
              errv_d = 1'b1;
              erra_d = exp_q;
              errd_d = rdata_data;
            end
`endif
          end
          if (chk_q + A_ONE == len_q) state_d = DONE;
        end
        case ({rd_acc, rdata_valid})
          2'b10:   out_d = out_q + OUT_ONE;
          2'b01:   out_d = out_q - OUT_ONE;
          default: out_d = out_q;
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      chk_q   <= '0;
      seed_q  <= '0;
      out_q   <= '0;
      err_q   <= '0;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
      errv_q  <= 1'b0;
      erra_q  <= '0;
      errd_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      chk_q   <= chk_d;
      seed_q  <= seed_d;
      out_q   <= out_d;
      err_q   <= err_d;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
      errv_q  <= errv_d;
      erra_q  <= erra_d;
      errd_q  <= errd_d;
`endif
    end
  end

  assign cmd_addr   = cmd_valid ? addr_q : '0;
  assign wdata_we   = {(DATA_W/8){wdata_valid}};
  assign wdata_data = wdata_valid ? wr_pat : '0;
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
  assign err_addr   = erra_q;
  assign err_data   = errd_q;
  assign err_valid  = errv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_native_port_bist.sv
`default_nettype none
// tb_native_port_bist : scoreboard bench with a behavioural LiteDRAM native-port memory.
module tb_native_port_bist;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 256;
  localparam int MAX_OUT = 8;
  localparam int ERR_W   = 16;

  typedef logic [DATA_W-1:0] vec_t;
  typedef struct { logic [ADDR_W-1:0] addr; vec_t data; } wr_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;

  logic                user_clk = 1'b0;
  logic                user_rst_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W-1:0]   length = '0;
  logic [31:0]         seed = '0;
  logic                busy, done, pass;
  logic [ERR_W-1:0]    err_count;
  logic                cmd_valid, cmd_we;
  logic                cmd_ready = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                wdata_valid;
  logic                wdata_ready = 1'b0;
  logic [DATA_W/8-1:0] wdata_we;
  logic [DATA_W-1:0]   wdata_data;
  logic                rdata_valid = 1'b0;
  logic                rdata_ready;
  logic [DATA_W-1:0]   rdata_data = '0;
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
  logic [ADDR_W-1:0]   err_addr;
  logic [DATA_W-1:0]   err_data;
  logic                err_valid;
`endif

  native_port_bist #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .ERR_W(ERR_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .seed        (seed),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata_we    (wdata_we),
    .wdata_data  (wdata_data),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata_data  (rdata_data)
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
    ,
    .err_addr    (err_addr),
    .err_data    (err_data),
    .err_valid   (err_valid)
`endif
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  int                n_vec = 0;
  int                n_miss = 0;
  int                lat = 3;
  int                corrupt_k = -1;
  bit                rnd_ready = 1'b0;
  int                rd_k = 0;
  int                last_rd_cyc = 0;
  int                max_out = 0;
  int                n_cmd_valid = 0;
  int                run_len = 0;
  logic [ADDR_W-1:0] wr_addr_cur = '0;
  wr_exp_t           exp_wr_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];
  pend_t             pend[$];
  vec_t              mem [logic [ADDR_W-1:0]];

  task automatic chk(input string tag, input vec_t act, input vec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic vec_t pat(input logic [31:0] s, input logic [ADDR_W-1:0] a);
    vec_t       v;
    logic [2:0] ln;
    v = '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      ln = 3'(i);
      v[32*i +: 32] = s ^ {ln, 4'h0, a[24:0]};
    end
    return v;
  endfunction

  // Memory model: inputs set here apply to the next rising edge.
  always @(negedge user_clk) begin : model
    pend_t   p;
    vec_t    d;
    wr_exp_t e;
    cmd_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    wdata_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cmd_valid) n_cmd_valid++;
    rdata_valid = 1'b0;
    rdata_data  = '0;
    if (rdata_ready && pend.size() > 0 && pend[0].due <= cyc + 1) begin
      p = pend.pop_front();
      d = mem.exists(p.addr) ? mem[p.addr] : '0;
      if (rd_k == corrupt_k) d[0] = ~d[0];
      rd_k++;
      last_rd_cyc = cyc;
      rdata_valid = 1'b1;
      rdata_data  = d;
    end
    if (cmd_valid && cmd_ready) begin
      if (cmd_we) begin
        if (exp_wr_q.size() == 0) chk("extra_wr", vec_t'(exp_wr_q.size()), vec_t'(1));
        else chk("wr_addr", vec_t'(cmd_addr), vec_t'(exp_wr_q[0].addr));
        wr_addr_cur = cmd_addr;
      end else begin
        if (exp_rd_q.size() == 0) chk("extra_rd", vec_t'(exp_rd_q.size()), vec_t'(1));
        else chk("rd_addr", vec_t'(cmd_addr), vec_t'(exp_rd_q.pop_front()));
        chk("rd_after_wr", vec_t'(exp_wr_q.size()), vec_t'(0));
        p.addr = cmd_addr;
        p.due  = cyc + 1 + lat;
        pend.push_back(p);
      end
    end
    if (wdata_valid && wdata_ready) begin
      if (exp_wr_q.size() == 0) chk("extra_wdata", vec_t'(exp_wr_q.size()), vec_t'(1));
      else begin
        e = exp_wr_q.pop_front();
        chk("wr_data", wdata_data, e.data);
      end
      chk("wr_be", vec_t'(wdata_we), vec_t'({(DATA_W/8){1'b1}}));
      mem[wr_addr_cur] = wdata_data;
    end
    if (pend.size() > max_out) max_out = pend.size();
  end

  task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                           input logic [31:0] s, input int latency, input int corrupt,
                           input bit rnd);
    wr_exp_t e;
    lat       = latency;
    corrupt_k = corrupt;
    rnd_ready = rnd;
    rd_k      = 0;
    max_out   = 0;
    run_len   = int'(l);
    for (int k = 0; k < int'(l); k++) begin
      e.addr = b + ADDR_W'(k);
      e.data = pat(s, e.addr);
      exp_wr_q.push_back(e);
      exp_rd_q.push_back(e.addr);
    end
    @(negedge user_clk);
    base_addr = b;
    length    = l;
    seed      = s;
    start     = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    chk("start_lat", vec_t'(cmd_valid), vec_t'(l != '0));
    chk("busy", vec_t'(busy), vec_t'(l != '0));
  endtask

  task automatic finish_run(input int exp_err);
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge user_clk);
      n++;
    end
    chk("done", vec_t'(done), vec_t'(1));
    if (run_len != 0) chk("done_lat", vec_t'(cyc), vec_t'(last_rd_cyc + 1));
    chk("busy_at_done", vec_t'(busy), vec_t'(0));
    chk("err_count", vec_t'(err_count), vec_t'(exp_err));
    chk("pass", vec_t'(pass), vec_t'(exp_err == 0));
    chk("wr_left", vec_t'(exp_wr_q.size()), vec_t'(0));
    chk("rd_left", vec_t'(exp_rd_q.size()), vec_t'(0));
    chk("rd_pend", vec_t'(pend.size()), vec_t'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n;
    vec_t v;
    repeat (3) @(negedge user_clk);
    chk("rst_ctrl", vec_t'({busy, done, pass, cmd_valid, wdata_valid, rdata_ready}), vec_t'(0));
    chk("rst_err", vec_t'(err_count), vec_t'(0));
    chk("rst_wdata", wdata_data, vec_t'(0));
    user_rst_n = 1'b1;

    start_run(25'h0, 25'd4, 32'h0, 3, -1, 1'b0);
    finish_run(0);
    v = mem[25'd2];
    chk("lane0_b2", vec_t'(v[31:0]), vec_t'(32'h0000_0002));
    chk("lane7_b2", vec_t'(v[255:224]), vec_t'(32'hE000_0002));

    start_run(25'h0, 25'd4, 32'h0, 3, 1, 1'b0);
    finish_run(1);
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
    v = pat(32'h0, 25'd1);
    v[0] = ~v[0];
    chk("err_valid", vec_t'(err_valid), vec_t'(1));
    chk("err_addr", vec_t'(err_addr), vec_t'(1));
    chk("err_data", err_data, v);
`endif

    n = n_cmd_valid;
    start_run(25'h5, 25'd0, 32'h1234, 3, -1, 1'b0);
    finish_run(0);
    repeat (3) @(negedge user_clk);
    chk("len0_no_cmd", vec_t'(n_cmd_valid - n), vec_t'(0));
    chk("len0_done_hold", vec_t'(done), vec_t'(1));
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
    chk("len0_err_valid", vec_t'(err_valid), vec_t'(0));
`endif

    start_run(25'h1FF_FFFE, 25'd4, 32'hCAFE_F00D, 3, -1, 1'b0);
    finish_run(0);

    start_run(25'h1000, 25'd32, 32'h0F0F_1234, 40, -1, 1'b0);
    finish_run(0);
    chk("max_out", vec_t'(max_out), vec_t'(MAX_OUT));

    start_run(25'h0A_BCDE, 25'd16, 32'hDEAD_BEEF, 5, 7, 1'b1);
    finish_run(1);
`ifdef NATIVE_PORT_BIST_ERRCAP_EN
    chk("err_addr_rnd", vec_t'(err_addr), vec_t'(25'h0A_BCE5));
`endif

    start_run(25'h40, 25'd32, 32'h5A5A_0001, 40, -1, 1'b0);
    n = 0;
    while (pend.size() < 5 && n < 2000) begin
      @(posedge user_clk);
      n++;
    end
    chk("rst_out5", vec_t'(pend.size()), vec_t'(5));
    @(negedge user_clk);
    user_rst_n = 1'b0;
    @(posedge user_clk);
    #1;
    pend.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(negedge user_clk);
    user_rst_n = 1'b1;
    chk("rst_mid_ctrl", vec_t'({busy, done, pass, cmd_valid, wdata_valid, rdata_ready}), vec_t'(0));
    chk("rst_mid_err", vec_t'(err_count), vec_t'(0));

    start_run(25'h40, 25'd32, 32'h5A5A_0002, 3, -1, 1'b0);
    finish_run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
